nn_layer_seq: RTL and testbench
===============================

Name: nn_layer_seq

Overview:
- Parametrised successor of the 4x4 perceptron network.
- A single time-multiplexed signed MAC evaluates N_NEURON neurons of N_IN inputs each, one product per cycle.
- Weights, biases and inputs are loaded over byte streams. Activation is selectable: step or shifted/saturated ReLU.
- Chain mode feeds the layer's own outputs back as the next inputs, enabling multi-pass operation.
- Sits between the top-level pin mux (ui_in/uo_out) and the controller FSM.

Parameters:
- N_IN, 4, inputs per neuron (>=1)
- N_NEURON, 4, neurons in layer (>=1)
- DW, 8, data/weight/bias width, signed two's complement
- ACC_W, 20, accumulator width; must be >= 2*DW + clog2(N_IN+1)
- SHIFT, 0, arithmetic right shift applied before ReLU saturation

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  cfg_data byte valid this cycle
- cfg_data  in  DW  order per neuron n=0..N_NEURON-1: w[n][0..N_IN-1], then b[n]
- in_valid  in  1  in_data valid this cycle
- in_data  in  DW  inputs x[0..N_IN-1], in order
- start  in  1  pulse; begin evaluation
- chain  in  1  sampled with start; 1 = use previous out_vec as inputs
- act_sel  in  1  sampled with start; 0 = step, 1 = ReLU
- threshold  in  DW  signed step threshold, sign-extended to ACC_W
- out_sel  in  clog2(N_NEURON)  neuron index for out_byte
- busy  out  1  evaluation in progress
- done  out  1  one-cycle pulse, results valid
- cfg_loaded  out  1  full parameter set received
- err  out  1  sticky protocol error
- out_vec  out  N_NEURON*DW  neuron n occupies bits [n*DW +: DW]
- out_byte  out  DW  out_vec slice selected by out_sel (combinational)

Behaviour:
- Reset (async, any time, including mid-evaluation): FSM to IDLE. All weights, biases, inputs, out_vec, pointers and accumulator cleared to 0. busy=0, done=0, cfg_loaded=0, err=0. Any partial result is discarded.
- FSM states: IDLE, MAC, ACT, DONE.
  - IDLE->MAC: start=1 and cfg_loaded=1.
  - MAC->ACT: after N_IN MAC cycles for the current neuron.
  - ACT->MAC: next neuron remains.
  - ACT->DONE: last neuron written.
  - DONE->IDLE: unconditional.
- Load ports are accepted only in IDLE.
  - cfg_valid: writes the byte at cfg_ptr, then increments cfg_ptr. cfg_ptr wraps to 0 after (N_IN+1)*N_NEURON-1; cfg_loaded is set on that wrap and stays set.
  - in_valid: writes x[in_ptr]. in_ptr wraps after N_IN-1, with no flag.
  - cfg_valid and in_valid in the same cycle: both accepted.
- Start:
  - start in IDLE with cfg_loaded=0: ignored, err set.
  - start together with cfg_valid or in_valid: start wins, both load bytes are dropped, err set.
  - start, cfg_valid or in_valid while busy or in DONE: ignored, err set.
- Chain:
  - chain=1 at an accepted start copies out_vec[i] into x[i] for i < min(N_IN, N_NEURON) on the start edge. Remaining x[i] are unchanged.
  - act_sel and chain are latched at start and held for the whole evaluation.
- Timing per neuron:
  - First MAC cycle: acc = sext(b[n]) + x[0]*w[n][0].
  - Subsequent MAC cycles: acc += x[k]*w[n][k].
  - Products are signed, 2*DW bits, sign-extended to ACC_W. No overflow is possible given the ACC_W rule.
- ACT cycle: writes out_vec[n].
  - step: out = (acc > threshold) ? 1 : 0, zero-extended to DW.
  - ReLU: s = acc >>> SHIFT; out = 0 if s<0, 2^(DW-1)-1 if s > 2^(DW-1)-1, else s[DW-1:0].
- Latency: with start accepted at edge k, busy=1 for cycles k+1 .. k+N_NEURON*(N_IN+1). done=1 with busy=0 in the following cycle. Defaults give 20 busy cycles and done at k+21.
- out_vec keeps previous values until each neuron's ACT cycle overwrites it, so it is partially updated during busy. It is consistent when done=1 and held until the next evaluation.
- err is cleared only by reset.
- out_byte is 0 when out_sel >= N_NEURON.

Test Plan:
- Load w[0][*]=1, b[0]=0, other neurons 0; inputs 1,2,3,4; act_sel=1; start -> busy for 20 cycles, done at k+21, out_vec[0]=10, others 0.
- Same weights, act_sel=0, threshold=9 -> out[0]=1; threshold=10 -> out[0]=0 (strict greater-than).
- w[1][*]=127, inputs all 127, b[1]=127, ReLU -> acc 64643, out[1]=127 (saturated). w[2][*]=-1 with inputs 1,2,3,4 -> out[2]=0 (ReLU), 0 (step, threshold 0).
- start before full cfg (19 of 20 bytes) -> no busy, err=1. 20th byte -> cfg_loaded=1; start then runs normally.
- Identity weights (w[n][n]=1, rest 0, biases 0), inputs 5,6,7,8, ReLU; then start with chain=1 and b[n]=1 -> second pass gives 6,7,8,9.
- Assert reset at busy cycle 7 -> busy, done and out_vec are 0 immediately, cfg_loaded=0; a following start is ignored with err=1.

Source files
------------

// File: rtl/nn_layer_seq.sv
// nn_layer_seq: one time-multiplexed signed MAC that evaluates a layer of
// N_NEURON neurons with N_IN inputs each, one product per clock.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   cfg_valid/cfg_data  parameter byte stream: for each neuron, its N_IN
//                       weights, then its bias
//   in_valid/in_data    input byte stream x[0..N_IN-1]
//   start               begin an evaluation (needs a complete parameter set)
//   chain               with start: copy the previous outputs into x[]
//   act_sel             with start: 0 = step, 1 = shifted/saturated ReLU
//   threshold           signed step threshold
//   out_sel             neuron index presented on out_byte
//   busy, done          evaluation running / one-cycle results-valid pulse
//   cfg_loaded          a full parameter set has been received
//   err                 sticky protocol error
//   out_vec, out_byte   all neuron outputs / the one selected by out_sel
module nn_layer_seq #(
  parameter int N_IN     = 4,
  parameter int N_NEURON = 4,
  parameter int DW       = 8,
  parameter int ACC_W    = 20,
  parameter int SHIFT    = 0,
  localparam int SEL_W   = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  input  logic [DW-1:0]          cfg_data,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  input  logic                   start,
  input  logic                   chain,
  input  logic                   act_sel,
  input  logic [DW-1:0]          threshold,
  input  logic [SEL_W-1:0]       out_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_loaded,
  output logic                   err,
  output logic [N_NEURON*DW-1:0] out_vec,
  output logic [DW-1:0]          out_byte
);
  localparam int IN_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CK_W    = $clog2(N_IN + 1);
  localparam int N_CHAIN = (N_IN < N_NEURON) ? N_IN : N_NEURON;
  localparam logic [IN_W-1:0]  K_LAST  = IN_W'(N_IN - 1);
  localparam logic [SEL_W-1:0] N_LAST  = SEL_W'(N_NEURON - 1);
  localparam logic [CK_W-1:0]  CK_BIAS = CK_W'(N_IN);
  localparam logic signed [ACC_W-1:0] RELU_MAX = ACC_W'((1 << (DW - 1)) - 1);

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;
  state_t state_q, state_d;

  logic signed [DW-1:0] w_mem [N_NEURON][N_IN];
  logic signed [DW-1:0] b_mem [N_NEURON];
  logic signed [DW-1:0] x_mem [N_IN];
  logic [DW-1:0]        out_mem [N_NEURON];

  logic [SEL_W-1:0] cfg_n;
  logic [CK_W-1:0]  cfg_k;
  logic [IN_W-1:0]  in_ptr;
  logic [SEL_W-1:0] mac_n;
  logic [IN_W-1:0]  mac_k;
  logic             act_sel_q;
  logic             start_ok, load_ok, err_set;

  logic signed [2*DW-1:0]  x_ext_p0, w_ext_p0, prod_p0;
  logic signed [ACC_W-1:0] prod_acc_p0, bias_acc_p0, acc_base_p0, acc_p1;
  logic [DW-1:0]           act_out_p1;

  function automatic logic [DW-1:0] step_act(input logic signed [ACC_W-1:0] a,
                                             input logic signed [DW-1:0]    thr);
    logic signed [ACC_W-1:0] thr_ext;
    thr_ext  = {{(ACC_W-DW){thr[DW-1]}}, thr};
    step_act = {{(DW-1){1'b0}}, (a > thr_ext)};
  endfunction

  function automatic logic [DW-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s < 0)             relu_sat = '0;
    else if (s > RELU_MAX) relu_sat = RELU_MAX[DW-1:0];
    else                   relu_sat = s[DW-1:0];
  endfunction

  // Stage p0: one signed product per cycle; the first product of a neuron
  // starts from its bias instead of the running sum.
  assign x_ext_p0    = {{DW{x_mem[mac_k][DW-1]}}, x_mem[mac_k]};
  assign w_ext_p0    = {{DW{w_mem[mac_n][mac_k][DW-1]}}, w_mem[mac_n][mac_k]};
  assign prod_p0     = x_ext_p0 * w_ext_p0;
  assign prod_acc_p0 = {{(ACC_W-2*DW){prod_p0[2*DW-1]}}, prod_p0};
  assign bias_acc_p0 = {{(ACC_W-DW){b_mem[mac_n][DW-1]}}, b_mem[mac_n]};
  assign acc_base_p0 = (mac_k == '0) ? bias_acc_p0 : acc_p1;

  // Stage p1: activation of the completed accumulator.
  assign act_out_p1 = act_sel_q ? relu_sat(acc_p1) : step_act(acc_p1, $signed(threshold));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    start_ok = 1'b0;
    load_ok  = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // start always wins over load bytes in the same cycle
          if (cfg_loaded) begin
            start_ok = 1'b1;
            state_d  = MAC;
          end
          err_set = !cfg_loaded || cfg_valid || in_valid;
        end else begin
          load_ok = 1'b1;
        end
      end
      MAC: begin
        busy    = 1'b1;
        err_set = start || cfg_valid || in_valid;
        if (mac_k == K_LAST) state_d = ACT;
      end
      ACT: begin
        busy    = 1'b1;
        err_set = start || cfg_valid || in_valid;
        state_d = (mac_n == N_LAST) ? DONE : MAC;
      end
      DONE: begin
        done    = 1'b1;
        err_set = start || cfg_valid || in_valid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_NEURON; n++) begin
        for (int i = 0; i < N_IN; i++) w_mem[n][i] <= '0;
        b_mem[n]   <= '0;
        out_mem[n] <= '0;
      end
      for (int i = 0; i < N_IN; i++) x_mem[i] <= '0;
      cfg_n      <= '0;
      cfg_k      <= '0;
      in_ptr     <= '0;
      mac_n      <= '0;
      mac_k      <= '0;
      acc_p1     <= '0;
      act_sel_q  <= 1'b0;
      cfg_loaded <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= err | err_set;

      if (load_ok && cfg_valid) begin
        if (cfg_k == CK_BIAS) begin
          b_mem[cfg_n] <= $signed(cfg_data);
          cfg_k        <= '0;
          if (cfg_n == N_LAST) begin
            cfg_n      <= '0;
            cfg_loaded <= 1'b1;
          end else begin
            cfg_n <= cfg_n + SEL_W'(1);
          end
        end else begin
          w_mem[cfg_n][cfg_k[IN_W-1:0]] <= $signed(cfg_data);
          cfg_k <= cfg_k + CK_W'(1);
        end
      end

      if (load_ok && in_valid) begin
        x_mem[in_ptr] <= $signed(in_data);
        in_ptr        <= (in_ptr == K_LAST) ? '0 : in_ptr + IN_W'(1);
      end

      if (start_ok) begin
        act_sel_q <= act_sel;
        mac_n     <= '0;
        mac_k     <= '0;
        if (chain) begin
          for (int i = 0; i < N_CHAIN; i++) x_mem[i] <= $signed(out_mem[i]);
        end
      end

      if (state_q == MAC) begin
        acc_p1 <= acc_base_p0 + prod_acc_p0;
        mac_k  <= (mac_k == K_LAST) ? '0 : mac_k + IN_W'(1);
      end

      if (state_q == ACT) begin
        out_mem[mac_n] <= act_out_p1;
        if (mac_n != N_LAST) mac_n <= mac_n + SEL_W'(1);
      end
    end
  end

  always_comb begin
    out_vec = '0;
    for (int i = 0; i < N_NEURON; i++) out_vec[i*DW +: DW] = out_mem[i];
  end

  always_comb begin
    out_byte = '0;
    if (int'(out_sel) < N_NEURON) out_byte = out_mem[out_sel];
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// tb_nn_layer_seq: randomized and directed stimulus for nn_layer_seq with a
// scoreboard; each accepted start pushes the expected layer result, and a
// monitor compares it when the design pulses done.
module tb_nn_layer_seq;
  localparam int N_IN     = 4;
  localparam int N_NEURON = 4;
  localparam int DW       = 8;
  localparam int ACC_W    = 20;
  localparam int SHIFT    = 0;
  localparam int SEL_W    = 2;
  localparam int BUSY_LEN = N_NEURON * (N_IN + 1);
  localparam int N_CFG    = (N_IN + 1) * N_NEURON;
  localparam int N_CHAIN  = (N_IN < N_NEURON) ? N_IN : N_NEURON;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   cfg_valid = 1'b0, in_valid = 1'b0;
  logic [DW-1:0]          cfg_data = '0, in_data = '0;
  logic                   start = 1'b0, chain = 1'b0, act_sel = 1'b0;
  logic [DW-1:0]          threshold = '0;
  logic [SEL_W-1:0]       out_sel = '0;
  logic                   busy, done, cfg_loaded, err;
  logic [N_NEURON*DW-1:0] out_vec;
  logic [DW-1:0]          out_byte;

  always #5 clk = ~clk;

  nn_layer_seq #(.N_IN(N_IN), .N_NEURON(N_NEURON), .DW(DW), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_data(in_data), .start(start), .chain(chain),
    .act_sel(act_sel), .threshold(threshold), .out_sel(out_sel),
    .busy(busy), .done(done), .cfg_loaded(cfg_loaded), .err(err),
    .out_vec(out_vec), .out_byte(out_byte)
  );

  int tests = 0;
  int fails = 0;

  // reference model state: what the layer should hold
  int mw[N_NEURON][N_IN];
  int mb[N_NEURON];
  int mx[N_IN];
  int mout[N_NEURON];
  int mptr;
  // staging values for the next load
  int pw[N_NEURON][N_IN];
  int pb[N_NEURON];
  int px[N_IN];

  typedef struct {
    logic [N_NEURON*DW-1:0] vec;
    int                     sel;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   bcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int n = 0; n < N_NEURON; n++) begin
      for (int i = 0; i < N_IN; i++) mw[n][i] = 0;
      mb[n] = 0;
      mout[n] = 0;
    end
    for (int i = 0; i < N_IN; i++) mx[i] = 0;
    mptr = 0;
  endfunction

  function automatic void model_cfg(input int v);
    int n, k;
    n = mptr / (N_IN + 1);
    k = mptr % (N_IN + 1);
    if (k == N_IN) mb[n] = v;
    else mw[n][k] = v;
    mptr = (mptr + 1 == N_CFG) ? 0 : mptr + 1;
  endfunction

  // Neuron value straight from the definition: bias plus dot product, then activation.
  function automatic int model_neuron(input int n, input bit relu, input int thr);
    int acc, s;
    acc = mb[n];
    for (int i = 0; i < N_IN; i++) acc += mx[i] * mw[n][i];
    if (!relu) return (acc > thr) ? 1 : 0;
    s = acc >>> SHIFT;
    if (s < 0) return 0;
    if (s > 2**(DW-1) - 1) return 2**(DW-1) - 1;
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    model_clear();
    cyc();
  endtask

  task automatic load_cfg(input int first, input int last_excl, input bit with_x);
    int n, k, v;
    for (int j = first; j < last_excl; j++) begin
      n = j / (N_IN + 1);
      k = j % (N_IN + 1);
      v = (k == N_IN) ? pb[n] : pw[n][k];
      cfg_valid = 1'b1;
      cfg_data  = 8'(v);
      if (with_x && j < N_IN) begin
        in_valid = 1'b1;
        in_data  = 8'(px[j]);
        mx[j]    = px[j];
      end
      cyc();
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      model_cfg(v);
    end
  endtask

  task automatic load_x();
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(px[i]);
      cyc();
      in_valid = 1'b0;
      mx[i] = px[i];
    end
  endtask

  task automatic stage_clear();
    for (int n = 0; n < N_NEURON; n++) begin
      for (int i = 0; i < N_IN; i++) pw[n][i] = 0;
      pb[n] = 0;
    end
  endtask

  // Start an evaluation the model expects to be accepted and wait for done.
  task automatic run(input bit ch, input bit relu, input int thr, input int sel, input bit junk);
    exp_t e;
    int   cnt;
    if (ch) for (int i = 0; i < N_CHAIN; i++) mx[i] = mout[i];
    e.vec = '0;
    for (int n = 0; n < N_NEURON; n++) begin
      mout[n] = model_neuron(n, relu, thr);
      e.vec[n*DW +: DW] = 8'(mout[n]);
    end
    e.sel = sel;
    sb_q.push_back(e);
    start = 1'b1; chain = ch; act_sel = relu;
    threshold = 8'(thr); out_sel = SEL_W'(sel);
    if (junk) begin
      cfg_valid = 1'b1; cfg_data = 8'h5a;
      in_valid  = 1'b1; in_data  = 8'h33;
    end
    cyc();
    start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0;
    chain = ~ch; act_sel = ~relu;
    check("busy_after_start", busy, 1);
    cnt = 0;
    while (!done && cnt < 200) begin
      cyc();
      cnt++;
    end
    check("done_latency", cnt, BUSY_LEN);
    check("busy_at_done", busy, 0);
    cyc();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        check("busy_len", bcnt, BUSY_LEN);
        bcnt = 0;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done, expected no result pending");
        end else begin
          mon_e = sb_q.pop_front();
          check("out_vec", out_vec, mon_e.vec);
          check("out_byte", out_byte, mon_e.vec[mon_e.sel*DW +: DW]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int r;
    bit wide;
    model_clear();
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_loaded", cfg_loaded, 0);
    check("rst_err", err, 0);
    check("rst_out_vec", out_vec, 0);
    check("rst_out_byte", out_byte, 0);

    // incomplete parameter set: start is refused
    stage_clear();
    for (int i = 0; i < N_IN; i++) begin
      pw[0][i] = 1;
      px[i] = i + 1;
    end
    load_cfg(0, N_CFG - 1, 1'b0);
    check("partial_cfg_loaded", cfg_loaded, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("early_start_busy", busy, 0);
    check("early_start_err", err, 1);
    load_cfg(N_CFG - 1, N_CFG, 1'b0);
    check("full_cfg_loaded", cfg_loaded, 1);
    load_x();
    run(1'b0, 1'b1, 0, 0, 1'b0);
    check("sum_relu", out_vec, {8'd0, 8'd0, 8'd0, 8'd10});

    do_reset();
    check("rst2_err", err, 0);
    check("rst2_cfg_loaded", cfg_loaded, 0);

    // sum of 1..4 with ReLU and strict step threshold
    load_cfg(0, N_CFG, 1'b1);
    run(1'b0, 1'b1, 0, 0, 1'b0);
    check("sum_relu2", out_vec, {8'd0, 8'd0, 8'd0, 8'd10});
    run(1'b0, 1'b0, 9, 0, 1'b0);
    check("step_thr9", out_vec, {8'd0, 8'd0, 8'd0, 8'd1});
    run(1'b0, 1'b0, 10, 0, 1'b0);
    check("step_thr10", out_vec, 0);

    // saturation and negative sums
    stage_clear();
    for (int i = 0; i < N_IN; i++) begin
      pw[1][i] = 127;
      pw[2][i] = -1;
      px[i] = 127;
    end
    pb[1] = 127;
    load_cfg(0, N_CFG, 1'b1);
    run(1'b0, 1'b1, 0, 1, 1'b0);
    check("relu_sat", out_byte, 127);
    for (int i = 0; i < N_IN; i++) px[i] = i + 1;
    load_x();
    run(1'b0, 1'b1, 0, 2, 1'b0);
    check("relu_neg", out_byte, 0);
    run(1'b0, 1'b0, 0, 2, 1'b0);
    check("step_neg", out_byte, 0);

    // identity layer, then a chained second pass with bias 1
    stage_clear();
    for (int n = 0; n < N_NEURON; n++) pw[n][n] = 1;
    for (int i = 0; i < N_IN; i++) px[i] = i + 5;
    load_cfg(0, N_CFG, 1'b1);
    run(1'b0, 1'b1, 0, 3, 1'b0);
    check("identity", out_vec, {8'd8, 8'd7, 8'd6, 8'd5});
    for (int n = 0; n < N_NEURON; n++) pb[n] = 1;
    load_cfg(0, N_CFG, 1'b0);
    run(1'b1, 1'b1, 0, 3, 1'b0);
    check("chain_pass", out_vec, {8'd9, 8'd8, 8'd7, 8'd6});

    // reset in the middle of an evaluation
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_out_vec", out_vec, 0);
    check("mid_rst_cfg_loaded", cfg_loaded, 0);
    cyc();
    reset = 1'b0;
    model_clear();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("post_rst_start_busy", busy, 0);
    check("post_rst_start_err", err, 1);

    // start colliding with load bytes: evaluation runs, bytes dropped
    do_reset();
    load_cfg(0, N_CFG, 1'b1);
    check("pre_collide_err", err, 0);
    run(1'b0, 1'b1, 0, 0, 1'b1);
    check("collide_err", err, 1);

    // randomized evaluations
    for (int t = 0; t < 25; t++) begin
      wide = 1'($urandom_range(0, 1));
      for (int n = 0; n < N_NEURON; n++) begin
        for (int i = 0; i < N_IN; i++)
          pw[n][i] = wide ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 8)) - 4;
        pb[n] = int'($urandom_range(0, 255)) - 128;
      end
      for (int i = 0; i < N_IN; i++)
        px[i] = wide ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 16)) - 8;
      r = int'($urandom_range(0, 2));
      load_cfg(0, N_CFG, r == 0);
      if (r == 1) load_x();
      run(r == 2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
          int'($urandom_range(0, N_NEURON - 1)), 1'b0);
    end

    repeat (3) cyc();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
